// File: rtl/dmem_if.sv
// Load/store request and in-order response channels between the MEM stage
// (master) and the data-memory responder (slave).
interface dmem_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [BE_WIDTH-1:0]   req_be;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: synchronous word RAM behind a fixed-latency pipeline,
// returning one in-order response per request through a credit-limited FIFO.
module dmem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic     clk,
    input  logic     rst,
    dmem_if.slave    bus,
    output logic     busy
);
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_WIDTH = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned NUM_STAGE = LATENCY - 1;
    localparam int unsigned RAM_WORDS = 2 ** ADDR_WIDTH;

    logic [CNT_WIDTH-1:0]  out_cnt;
    logic [CNT_WIDTH-1:0]  fifo_cnt;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  accept;
    logic                  pop;
    logic                  push;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] word_idx;

    logic [DATA_WIDTH-1:0] mem [RAM_WORDS];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] tail_data;
    logic [NUM_STAGE-1:0]  stage_v;
    logic [NUM_STAGE-1:0]  stage_err;

    logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  fifo_err;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(RSP_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    // Credit check uses registered count only, so ready never depends on this cycle's inputs
    assign bus.req_ready = !rst && (out_cnt < CNT_WIDTH'(RSP_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign req_err       = (bus.req_addr[1:0] != 2'b00) ||
                           ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign word_idx      = bus.req_addr[ADDR_WIDTH+1:2];
    assign push          = stage_v[NUM_STAGE-1];

    // RAM array: byte-masked write at the acceptance edge, contents survive reset
    always_ff @(posedge clk) begin
        if (accept && !req_err && bus.req_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (bus.req_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stage 1: registered RAM output, forced to zero for stores and errored requests
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_q <= '0;
        end else if (accept) begin
            ram_q <= (req_err || bus.req_we) ? '0 : mem[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_v   <= '0;
            stage_err <= '0;
        end else begin
            stage_v   <= NUM_STAGE'({stage_v, accept});
            stage_err <= NUM_STAGE'({stage_err, req_err});
        end
    end

    // Data delay for stages 2..LATENCY-1; validity travels in stage_v
    if (LATENCY > 2) begin : g_dly
        localparam int unsigned DLY_WIDTH = (LATENCY - 2) * DATA_WIDTH;
        logic [DLY_WIDTH-1:0] dly_q;

        always_ff @(posedge clk) begin
            dly_q <= DLY_WIDTH'({dly_q, ram_q});
        end

        assign tail_data = dly_q[DLY_WIDTH-1 -: DATA_WIDTH];
    end else begin : g_no_dly
        assign tail_data = ram_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= tail_data;
            fifo_err[wr_ptr]  <= stage_err[NUM_STAGE-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_WIDTH'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_WIDTH'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({accept, pop})
                2'b10:   out_cnt <= out_cnt + CNT_WIDTH'(1);
                2'b01:   out_cnt <= out_cnt - CNT_WIDTH'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign bus.rsp_valid = !rst && (fifo_cnt != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? fifo_data[rd_ptr] : '0;
    assign bus.rsp_err   = bus.rsp_valid && fifo_err[rd_ptr];
    assign busy          = !rst && (out_cnt != '0);
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a shadow-memory
// and response-queue reference model.
module tb_dmem_responder;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEP   = 4;
    localparam int unsigned WORDS = 2 ** AW;
    localparam int unsigned BYTES = 4 * WORDS;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [31:0] mask;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    dmem_if #(.DATA_WIDTH(DW)) bus ();

    dmem_responder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT),
        .RSP_DEPTH (DEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .busy(busy)
    );

    rsp_t        exp_q[$];
    rsp_t        got_q[$];
    logic [31:0] shadow [WORDS];
    logic [3:0]  known  [WORDS];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n_acc  = 0;
    int          n_pop  = 0;
    logic        s_ready, s_valid, s_err, s_busy;
    logic [31:0] s_rdata;

    // Reference: word-addressed shadow memory with per-byte "written" tracking
    function automatic rsp_t model(input logic we, input logic [3:0] be,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        rsp_t r;
        int   idx;
        r.cyc  = cyc;
        r.data = '0;
        r.mask = '1;
        r.err  = (addr % 4 != 0) || (addr >= BYTES);
        if (!r.err) begin
            idx = int'(addr / 4);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        shadow[idx][8*b +: 8] = wdata[8*b +: 8];
                        known[idx][b]         = 1'b1;
                    end
                end
            end else begin
                r.data = shadow[idx];
                for (int b = 0; b < 4; b++) r.mask[8*b +: 8] = {8{known[idx][b]}};
            end
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    // One clock: sample outputs mid-cycle, log handshakes, then step past the edge
    task automatic cycle();
        rsp_t g;
        @(negedge clk);
        s_ready = bus.req_ready;
        s_valid = bus.rsp_valid;
        s_rdata = bus.rsp_rdata;
        s_err   = bus.rsp_err;
        s_busy  = busy;
        if (bus.req_valid && s_ready) begin
            exp_q.push_back(model(bus.req_we, bus.req_be, bus.req_addr, bus.req_wdata));
            n_acc++;
        end
        if (s_valid && bus.rsp_ready) begin
            g.err  = s_err;
            g.data = s_rdata;
            g.mask = '1;
            g.cyc  = cyc;
            got_q.push_back(g);
            n_pop++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output bit timeout);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 50 && n_pop != n_acc; i++) cycle();
        timeout = (n_pop != n_acc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'hF, 32'h40, 32'h1234_5678);
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b exp 0", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h exp 0", bus.rsp_rdata); end
        if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b exp 0", bus.rsp_err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle();
        checks += 3;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b exp 1", s_ready); end
        if (s_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b exp 0", s_valid); end
        if (s_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b exp 0", s_busy); end
    endtask

    task automatic test_store_load();
        bit to;
        exp_q.delete(); got_q.delete();
        bus.rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF); cycle();
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);         cycle();
        drain(to);
        checks++;
        if (to || got_q.size() != 2) begin
            errors++; $display("FAIL store_load_count: got %0d exp 2", got_q.size());
        end else begin
            checks += 5;
            if (got_q[0].data !== 32'h0 || got_q[0].err !== 1'b0) begin errors++; $display("FAIL store_rsp: got %h/%b exp 0/0", got_q[0].data, got_q[0].err); end
            if (got_q[1].data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rsp: got %h exp deadbeef", got_q[1].data); end
            if (got_q[0].cyc - exp_q[0].cyc != LAT) begin errors++; $display("FAIL store_latency: got %0d exp %0d", got_q[0].cyc - exp_q[0].cyc, LAT); end
            if (got_q[1].cyc - exp_q[1].cyc != LAT) begin errors++; $display("FAIL load_latency: got %0d exp %0d", got_q[1].cyc - exp_q[1].cyc, LAT); end
            if (got_q[1].cyc != exp_q[0].cyc + 1 + LAT) begin errors++; $display("FAIL load_cycle: got %0d exp %0d", got_q[1].cyc, exp_q[0].cyc + 1 + LAT); end
        end
    endtask

    task automatic test_byte_enable();
        bit to;
        exp_q.delete(); got_q.delete();
        drive(1'b1, 1'b1, 4'hF,    32'h20, 32'h1122_3344); cycle();
        drive(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD); cycle();
        drive(1'b1, 1'b0, 4'h0,    32'h20, 32'h0);         cycle();
        drain(to);
        checks++;
        if (to || got_q.size() != 3) begin
            errors++; $display("FAIL byte_en_count: got %0d exp 3", got_q.size());
        end else begin
            checks += 2;
            if (got_q[1].data !== 32'h0) begin errors++; $display("FAIL byte_en_store_rsp: got %h exp 0", got_q[1].data); end
            if (got_q[2].data !== 32'h11BB_33DD) begin errors++; $display("FAIL byte_en_merge: got %h exp 11bb33dd", got_q[2].data); end
        end
    endtask

    task automatic test_errors();
        bit          to;
        logic [31:0] addrs [5] = '{32'h22, 32'h1000, 32'h12, 32'h1010, 32'h10};
        logic        wes   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        eerr  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] edata [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, wes[i], 4'hF, addrs[i], 32'h5555_5555);
            cycle();
        end
        drain(to);
        checks++;
        if (to || got_q.size() != 5) begin
            errors++; $display("FAIL err_count: got %0d exp 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i].err !== eerr[i] || got_q[i].data !== edata[i]) begin
                    errors++;
                    $display("FAIL err_rsp[%0d] addr %h: got %b/%h exp %b/%h", i, addrs[i], got_q[i].err, got_q[i].data, eerr[i], edata[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   to;
        logic exp_busy;
        exp_q.delete(); got_q.delete();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) drive(1'b1, 1'b1, 4'hF, 32'h100 + 32'(4 * i), $urandom);
            else        drive(1'b1, 1'b0, 4'h0, 32'h100 + 32'(4 * (i - 16)), 32'h0);
            exp_busy = (n_acc != n_pop);
            cycle();
            checks += 2;
            if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp 1", i, s_ready); end
            if (s_busy !== exp_busy) begin errors++; $display("FAIL b2b_busy[%0d]: got %b exp %b", i, s_busy, exp_busy); end
        end
        drain(to);
        checks++;
        if (to || got_q.size() != 32) begin
            errors++; $display("FAIL b2b_count: got %0d exp 32", got_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (got_q[i].err !== exp_q[i].err || (got_q[i].data & exp_q[i].mask) !== (exp_q[i].data & exp_q[i].mask)) begin
                    errors++; $display("FAIL b2b_rsp[%0d]: got %b/%h exp %b/%h", i, got_q[i].err, got_q[i].data, exp_q[i].err, exp_q[i].data);
                end
                if (i > 0) begin
                    checks++;
                    if (got_q[i].cyc != got_q[i-1].cyc + 1) begin errors++; $display("FAIL b2b_bubble[%0d]: got cycle %0d exp %0d", i, got_q[i].cyc, got_q[i-1].cyc + 1); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit          to;
        int          acc = 0;
        logic [31:0] head;
        exp_q.delete(); got_q.delete();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 4'h0, 32'h100 + 32'(4 * $urandom_range(0, 15)), 32'h0);
            cycle();
            if (s_ready) acc++;
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle();
        head = s_rdata;
        checks += 5;
        if (acc != DEP) begin errors++; $display("FAIL bp_accepted: got %0d exp %0d", acc, DEP); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b exp 0", s_ready); end
        if (s_valid !== 1'b1 || s_busy !== 1'b1) begin errors++; $display("FAIL bp_valid_busy: got %b/%b exp 1/1", s_valid, s_busy); end
        if (exp_q.size() == 0 || (s_rdata & exp_q[0].mask) !== (exp_q[0].data & exp_q[0].mask)) begin errors++; $display("FAIL bp_head: got %h", s_rdata); end
        cycle();
        if (s_rdata !== head) begin errors++; $display("FAIL bp_hold: got %h exp %h", s_rdata, head); end
        drain(to);
        checks++;
        if (to || got_q.size() != DEP) begin
            errors++; $display("FAIL bp_count: got %0d exp %0d", got_q.size(), DEP);
        end else begin
            for (int i = 0; i < int'(DEP); i++) begin
                checks++;
                if (got_q[i].err !== exp_q[i].err || (got_q[i].data & exp_q[i].mask) !== (exp_q[i].data & exp_q[i].mask)) begin
                    errors++; $display("FAIL bp_rsp[%0d]: got %b/%h exp %b/%h", i, got_q[i].err, got_q[i].data, exp_q[i].err, exp_q[i].data);
                end
            end
        end
        cycle();
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b exp 1", s_ready); end
    endtask

    task automatic test_random();
        bit          to;
        logic        exp_ready, exp_busy, hold;
        logic [31:0] prev_rdata, addr;
        logic        prev_err;
        int          k;
        exp_q.delete(); got_q.delete();
        hold = 1'b0; prev_rdata = '0; prev_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            if (k == 0)      addr = 32'h100 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
            else if (k == 1) addr = ($urandom | 32'h1000) & 32'hFFFF_FFFC;
            else             addr = 32'h100 + 32'(4 * $urandom_range(0, 31));
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom), addr, $urandom);
            bus.rsp_ready = $urandom_range(0, 9) < 7;
            exp_ready = (n_acc - n_pop) < int'(DEP);
            exp_busy  = (n_acc != n_pop);
            cycle();
            checks += 2;
            if (s_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b exp %b", i, s_ready, exp_ready); end
            if (s_busy !== exp_busy) begin errors++; $display("FAIL rand_busy[%0d]: got %b exp %b", i, s_busy, exp_busy); end
            if (hold) begin
                checks++;
                if (s_valid !== 1'b1 || s_rdata !== prev_rdata || s_err !== prev_err) begin
                    errors++; $display("FAIL rand_hold[%0d]: got %b/%h/%b exp 1/%h/%b", i, s_valid, s_rdata, s_err, prev_rdata, prev_err);
                end
            end
            hold = s_valid && !bus.rsp_ready;
            prev_rdata = s_rdata;
            prev_err = s_err;
        end
        drain(to);
        checks++;
        if (to || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d exp %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i].err !== exp_q[i].err || (got_q[i].data & exp_q[i].mask) !== (exp_q[i].data & exp_q[i].mask)) begin
                    errors++; $display("FAIL rand_rsp[%0d]: got %b/%h exp %b/%h", i, got_q[i].err, got_q[i].data, exp_q[i].err, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit to;
        exp_q.delete(); got_q.delete();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
            cycle();
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        cycle();
        checks += 2;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b exp 0", s_valid); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b exp 0", s_ready); end
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
        n_acc = 0; n_pop = 0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks += 3;
            if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_valid[%0d]: got %b exp 0", i, s_valid); end
            if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_stale_busy[%0d]: got %b exp 0", i, s_busy); end
            if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready[%0d]: got %b exp 1", i, s_ready); end
        end
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0); cycle();
        drive(1'b1, 1'b0, 4'h0, 32'h20, 32'h0); cycle();
        drain(to);
        checks++;
        if (to || got_q.size() != 2) begin
            errors++; $display("FAIL rst_reload_count: got %0d exp 2", got_q.size());
        end else begin
            checks += 2;
            if (got_q[0].data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_keep_10: got %h exp deadbeef", got_q[0].data); end
            if (got_q[1].data !== 32'h11BB_33DD) begin errors++; $display("FAIL rst_keep_20: got %h exp 11bb33dd", got_q[1].data); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < int'(WORDS); i++) known[i] = 4'h0;
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
